// File: rtl/exe_muldiv_unit_pkg.sv
// Shared definitions for the EXE-stage multiply/divide engine:
// command codes, FSM state encoding and command decode helpers.
package exe_muldiv_unit_pkg;

  localparam logic [3:0] EXE_MUL  = 4'b1100;  // signed multiply
  localparam logic [3:0] EXE_MULU = 4'b1101;  // unsigned multiply
  localparam logic [3:0] EXE_DIV  = 4'b1110;  // signed divide
  localparam logic [3:0] EXE_DIVU = 4'b1111;  // unsigned divide

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for any of the four commands this unit executes.
  function automatic logic is_md(input logic [3:0] cmd);
    return (cmd == EXE_MUL) || (cmd == EXE_MULU) ||
           (cmd == EXE_DIV) || (cmd == EXE_DIVU);
  endfunction

  function automatic logic is_div_cmd(input logic [3:0] cmd);
    return (cmd == EXE_DIV) || (cmd == EXE_DIVU);
  endfunction

  function automatic logic is_signed_cmd(input logic [3:0] cmd);
    return (cmd == EXE_MUL) || (cmd == EXE_DIV);
  endfunction

endpackage

// File: rtl/exe_muldiv_unit_datapath.sv
// Shared accumulator/shift register for the iterative multiplier and
// restoring divider. Operands are unsigned magnitudes; the top module
// applies sign correction. step_hi/step_lo are the values the registers
// take after the current step, exposed so the top can capture the final
// result on the same edge as the last step.
module muldiv_datapath
  import exe_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] step_hi,
  output logic [WIDTH-1:0] step_lo
);

  logic [WIDTH-1:0] hi_r;   // product high word / partial remainder
  logic [WIDTH-1:0] lo_r;   // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0] b_r;    // multiplicand / divisor
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH-1:0] diff_s;
  logic             ge_s;

  // One shift-add (multiply) or restoring shift-subtract (divide) step.
  always_comb begin
    sum_s     = {1'b0, hi_r} + {1'b0, b_r};
    shifted_s = {hi_r, lo_r[WIDTH-1]};
    ge_s      = (shifted_s >= {1'b0, b_r});
    // When ge_s holds the true difference is below b_r, so it fits WIDTH bits.
    diff_s    = shifted_s[WIDTH-1:0] - b_r;
    step_hi   = hi_r;
    step_lo   = lo_r;
    if (is_div) begin
      if (ge_s) begin
        step_hi = diff_s;
        step_lo = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = shifted_s[WIDTH-1:0];
        step_lo = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (lo_r[0]) begin
        step_hi = sum_s[WIDTH:1];
        step_lo = {sum_s[0], lo_r[WIDTH-1:1]};
      end else begin
        step_hi = {1'b0, hi_r[WIDTH-1:1]};
        step_lo = {hi_r[0], lo_r[WIDTH-1:1]};
      end
    end
  end

  // Operand load on accept, then one step per BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
      b_r  <= '0;
    end else if (load) begin
      hi_r <= '0;
      lo_r <= a;
      b_r  <= b;
    end else if (step) begin
      hi_r <= step_hi;
      lo_r <= step_lo;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

endmodule

// File: rtl/exe_muldiv_unit.sv
// EXE-stage multi-cycle multiply/divide unit. Owns the IDLE/BUSY/DONE
// FSM, the iteration counter, the pipeline Freeze request and the final
// sign correction of product, quotient and remainder.
module exe_muldiv_unit
  import exe_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [3:0]       EXE_CMD,
  input  logic [WIDTH-1:0] Val1,
  input  logic [WIDTH-1:0] Val2,
  input  logic [4:0]       Dest_in,
  input  logic             WB_EN_in,
  input  logic             Flush,
  output logic             Freeze,
  output logic             Busy,
  output logic             Res_valid,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Hi,
  output logic [4:0]       Dest,
  output logic             WB_EN
);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             is_div_r;
  logic             neg_q_r;     // product / quotient must be negated
  logic             neg_rem_r;   // remainder must be negated
  logic             div0_r;
  logic [4:0]       dest_lat_r;
  logic             wb_lat_r;
  logic             valid_r;
  logic             wb_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] hi_r;
  logic [4:0]       dest_r;

  logic             accept_s;
  logic             sgn_a_s;
  logic             sgn_b_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic [WIDTH-1:0] step_hi_s;
  logic [WIDTH-1:0] step_lo_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0] fix_res_s;
  logic [WIDTH-1:0] fix_hi_s;

  assign accept_s = (state_r == IDLE) && Start && is_md(EXE_CMD) && !Flush;
  assign sgn_a_s  = is_signed_cmd(EXE_CMD) && Val1[WIDTH-1];
  assign sgn_b_s  = is_signed_cmd(EXE_CMD) && Val2[WIDTH-1];
  assign mag_a_s  = sgn_a_s ? -Val1 : Val1;
  assign mag_b_s  = sgn_b_s ? -Val2 : Val2;

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .load    (accept_s),
    .step    (state_r == BUSY),
    .is_div  (is_div_r),
    .a       (mag_a_s),
    .b       (mag_b_s),
    .step_hi (step_hi_s),
    .step_lo (step_lo_s)
  );

  // Sign correction of the final step's magnitude results.
  always_comb begin
    prod_s     = {step_hi_s, step_lo_s};
    prod_fix_s = neg_q_r ? -prod_s : prod_s;
    if (is_div_r) begin
      // A zero divisor yields an all-ones quotient regardless of sign;
      // the remainder magnitude is |dividend|, so re-signing restores it.
      if (div0_r) begin
        fix_res_s = {WIDTH{1'b1}};
      end else begin
        fix_res_s = neg_q_r ? -step_lo_s : step_lo_s;
      end
      fix_hi_s = neg_rem_r ? -step_hi_s : step_hi_s;
    end else begin
      fix_res_s = prod_fix_s[WIDTH-1:0];
      fix_hi_s  = prod_fix_s[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM: accept, iterate WIDTH cycles, publish result for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      is_div_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_rem_r  <= 1'b0;
      div0_r     <= 1'b0;
      dest_lat_r <= 5'd0;
      wb_lat_r   <= 1'b0;
      valid_r    <= 1'b0;
      wb_r       <= 1'b0;
      result_r   <= '0;
      hi_r       <= '0;
      dest_r     <= 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
          wb_r    <= 1'b0;
          if (accept_s) begin
            state_r    <= BUSY;
            cnt_r      <= CNT_W'(WIDTH-1);
            is_div_r   <= is_div_cmd(EXE_CMD);
            neg_q_r    <= sgn_a_s ^ sgn_b_s;
            neg_rem_r  <= sgn_a_s;
            div0_r     <= (Val2 == '0);
            dest_lat_r <= Dest_in;
            wb_lat_r   <= WB_EN_in;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (Flush) begin
            state_r <= IDLE;
          end else if (cnt_r == '0) begin
            state_r  <= DONE;
            result_r <= fix_res_s;
            hi_r     <= fix_hi_s;
            dest_r   <= dest_lat_r;
            wb_r     <= wb_lat_r;
            valid_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          wb_r    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          wb_r    <= 1'b0;
        end
      endcase
    end
  end

  // A Flush arriving in DONE suppresses the pulse and the write-back.
  assign Res_valid = valid_r && !Flush;
  assign WB_EN     = wb_r && valid_r && !Flush;
  assign Busy      = (state_r == BUSY);
  // Combinational on the accept cycle so ID/EXE holds the command.
  assign Freeze    = accept_s || (state_r == BUSY);
  assign Result    = result_r;
  assign Hi        = hi_r;
  assign Dest      = dest_r;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed self-checking bench for exe_muldiv_unit.
module tb_exe_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [3:0]  EXE_CMD;
  logic [31:0] Val1;
  logic [31:0] Val2;
  logic [4:0]  Dest_in;
  logic        WB_EN_in;
  logic        Flush;
  logic        Freeze;
  logic        Busy;
  logic        Res_valid;
  logic [31:0] Result;
  logic [31:0] Hi;
  logic [4:0]  Dest;
  logic        WB_EN;

  int tests = 0;
  int fails = 0;

  // captured by do_op
  int          lat;
  int          frz_cnt;
  int          wb_bad;
  logic        frz0;
  logic        frz_at_valid;
  logic [31:0] cap_res;
  logic [31:0] cap_hi;
  logic [4:0]  cap_dest;
  logic        cap_wb;
  int          vcount;

  exe_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .EXE_CMD   (EXE_CMD),
    .Val1      (Val1),
    .Val2      (Val2),
    .Dest_in   (Dest_in),
    .WB_EN_in  (WB_EN_in),
    .Flush     (Flush),
    .Freeze    (Freeze),
    .Busy      (Busy),
    .Res_valid (Res_valid),
    .Result    (Result),
    .Hi        (Hi),
    .Dest      (Dest),
    .WB_EN     (WB_EN)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command (cycle 0), scramble inputs, run until Res_valid (bounded).
  task automatic do_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic w);
    Start = 1'b1; EXE_CMD = cmd; Val1 = a; Val2 = b; Dest_in = d; WB_EN_in = w;
    #1;
    frz0 = Freeze;
    lat = 0; frz_cnt = 0; wb_bad = 0; frz_at_valid = 1'b1;
    cap_res = '0; cap_hi = '0; cap_dest = '0; cap_wb = 1'b0;
    tick();
    Start = 1'b0; Val1 = ~a; Val2 = ~b; Dest_in = ~d; WB_EN_in = ~w;
    for (int k = 1; k <= 60; k++) begin
      if (Res_valid) begin
        lat = k; cap_res = Result; cap_hi = Hi; cap_dest = Dest; cap_wb = WB_EN;
        frz_at_valid = Freeze;
        break;
      end
      if (Freeze) frz_cnt++;
      if (WB_EN) wb_bad++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; EXE_CMD = 4'b0000; Val1 = 32'd0; Val2 = 32'd0;
    Dest_in = 5'd0; WB_EN_in = 1'b0; Flush = 1'b0;
    tick(); tick();
    chk("rst_result", Result, 32'd0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_freeze", {31'd0, Freeze}, 32'd0);
    chk("rst_valid", {31'd0, Res_valid}, 32'd0);
    chk("rst_dest", {27'd0, Dest}, 32'd0);
    rst = 1'b0;
    tick();

    // MULU with timing, Dest/WB_EN carry-through
    do_op(4'b1101, 32'hFFFF_FFFF, 32'h0000_0002, 5'd9, 1'b1);
    chk("mulu_latency", lat, 32'd33);
    chk("mulu_freeze_c0", {31'd0, frz0}, 32'd1);
    chk("mulu_freeze_busy", frz_cnt, 32'd32);
    chk("mulu_freeze_done", {31'd0, frz_at_valid}, 32'd0);
    chk("mulu_result", cap_res, 32'hFFFF_FFFE);
    chk("mulu_hi", cap_hi, 32'h0000_0001);
    chk("mulu_dest", {27'd0, cap_dest}, 32'd9);
    chk("mulu_wb_valid", {31'd0, cap_wb}, 32'd1);
    chk("mulu_wb_early", wb_bad, 32'd0);
    tick();
    chk("mulu_valid_pulse", {31'd0, Res_valid}, 32'd0);
    chk("mulu_wb_after", {31'd0, WB_EN}, 32'd0);
    chk("mulu_dest_hold", {27'd0, Dest}, 32'd9);
    chk("mulu_result_hold", Result, 32'hFFFF_FFFE);

    // Signed multiply -7 * 3 = -21
    do_op(4'b1100, 32'hFFFF_FFF9, 32'd3, 5'd1, 1'b1);
    chk("mul_result", cap_res, 32'hFFFF_FFEB);
    chk("mul_hi", cap_hi, 32'hFFFF_FFFF);
    tick();
    // Signed multiply -3 * -5 = 15
    do_op(4'b1100, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 5'd2, 1'b0);
    chk("mul_nn_result", cap_res, 32'd15);
    chk("mul_nn_hi", cap_hi, 32'd0);
    chk("mul_nn_wb", {31'd0, cap_wb}, 32'd0);
    tick();
    // Signed divide -7 / 2 = -3 rem -1
    do_op(4'b1110, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1);
    chk("div_result", cap_res, 32'hFFFF_FFFD);
    chk("div_hi", cap_hi, 32'hFFFF_FFFF);
    chk("div_latency", lat, 32'd33);
    tick();
    // Unsigned divide 100 / 7 = 14 rem 2
    do_op(4'b1111, 32'd100, 32'd7, 5'd4, 1'b1);
    chk("divu_result", cap_res, 32'd14);
    chk("divu_hi", cap_hi, 32'd2);
    tick();
    // Divide by zero
    do_op(4'b1111, 32'd100, 32'd0, 5'd5, 1'b1);
    chk("div0_result", cap_res, 32'hFFFF_FFFF);
    chk("div0_hi", cap_hi, 32'd100);
    tick();
    // Signed overflow
    do_op(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b1);
    chk("ovf_result", cap_res, 32'h8000_0000);
    chk("ovf_hi", cap_hi, 32'd0);
    tick();

    // Flush at BUSY cycle 10
    Start = 1'b1; EXE_CMD = 4'b1101; Val1 = 32'h0000_1234; Val2 = 32'h0000_5678;
    Dest_in = 5'd12; WB_EN_in = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    chk("flush_busy_before", {31'd0, Busy}, 32'd1);
    Flush = 1'b1;
    #1;
    chk("flush_freeze_same", {31'd0, Freeze}, 32'd1);
    tick();
    Flush = 1'b0;
    #1;
    chk("flush_busy_after", {31'd0, Busy}, 32'd0);
    chk("flush_freeze_after", {31'd0, Freeze}, 32'd0);
    chk("flush_no_valid", {31'd0, Res_valid}, 32'd0);
    do_op(4'b1101, 32'd3, 32'd5, 5'd13, 1'b1);
    chk("post_flush_latency", lat, 32'd33);
    chk("post_flush_result", cap_res, 32'd15);
    chk("post_flush_dest", {27'd0, cap_dest}, 32'd13);
    tick();

    // Reset mid-BUSY
    Start = 1'b1; EXE_CMD = 4'b1101; Val1 = 32'd7; Val2 = 32'd9;
    Dest_in = 5'd20; WB_EN_in = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    chk("midrst_result", Result, 32'd0);
    chk("midrst_hi", Hi, 32'd0);
    chk("midrst_busy", {31'd0, Busy}, 32'd0);
    chk("midrst_freeze", {31'd0, Freeze}, 32'd0);
    chk("midrst_dest", {27'd0, Dest}, 32'd0);
    rst = 1'b0;
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (Res_valid) vcount++;
      tick();
    end
    chk("midrst_no_valid", vcount, 32'd0);

    // Non-MD command and Flush-blocked accept
    Start = 1'b1; EXE_CMD = 4'b0000; Val1 = 32'd1; Val2 = 32'd1;
    #1;
    chk("nonmd_freeze", {31'd0, Freeze}, 32'd0);
    tick();
    chk("nonmd_busy", {31'd0, Busy}, 32'd0);
    EXE_CMD = 4'b1101; Flush = 1'b1;
    #1;
    chk("flush_idle_freeze", {31'd0, Freeze}, 32'd0);
    tick();
    chk("flush_idle_busy", {31'd0, Busy}, 32'd0);
    Start = 1'b0; Flush = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
